multicycle_controller: RTL and testbench

Control FSM for the multicycle RV32I core. Each instruction is sequenced as Fetch, Decode and 1–3 execute/writeback states. The block drives every datapath select, including `immsrc` for the immediate extender, and every write enable. It is a Moore FSM on `op`, with combinational ALU decode and branch resolution.

---
 rtl/riscv_pkg.sv | 69 ++++++
 rtl/alu_decoder.sv | 33 +++
 rtl/multicycle_controller.sv | 151 +++++++++++++++
 tb/tb_multicycle_controller.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I control path.
// Holds state encoding, opcodes, immediate-format codes and ALU codes
// so the controller, ALU decoder and datapath agree on every encoding.
package riscv_pkg;

  // State encoding (4 bits covers the eleven sequencing states).
  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTER = 4'd6;
  localparam logic [3:0] S_EXECUTEI = 4'd7;
  localparam logic [3:0] S_ALUWB    = 4'd8;
  localparam logic [3:0] S_BEQ      = 4'd9;
  localparam logic [3:0] S_JAL      = 4'd10;

  typedef enum logic [3:0] {
    FETCH    = S_FETCH,
    DECODE   = S_DECODE,
    MEMADR   = S_MEMADR,
    MEMREAD  = S_MEMREAD,
    MEMWB    = S_MEMWB,
    MEMWRITE = S_MEMWRITE,
    EXECUTER = S_EXECUTER,
    EXECUTEI = S_EXECUTEI,
    ALUWB    = S_ALUWB,
    BEQ      = S_BEQ,
    JAL      = S_JAL
  } state_t;

  // Opcodes (instr[6:0]).
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;

  // Immediate formats, same encoding as the extender's immsrc input.
  localparam logic [1:0] IMM_I = 2'b00;
  localparam logic [1:0] IMM_S = 2'b01;
  localparam logic [1:0] IMM_B = 2'b10;
  localparam logic [1:0] IMM_J = 2'b11;

  // ALU operation codes.
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;

  // Controller-to-ALU-decoder operation class.
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // Immediate format implied by the opcode; unsupported opcodes fall to I.
  function automatic logic [1:0] imm_for_op(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BEQ:  return IMM_B;
      OP_JAL:  return IMM_J;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU decoder: maps the controller's aluop class plus funct fields to alucontrol.
// Ports: aluop[1:0], funct3[2:0], op5 (instr[5]), funct7b5 (instr[30]) in;
//        alucontrol[2:0] out. Purely combinational.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       op5,
  input  logic       funct7b5,
  output logic [2:0] alucontrol
);

  always_comb begin
    alucontrol = ALU_ADD;
    case (aluop)
      ALUOP_ADD: alucontrol = ALU_ADD;
      ALUOP_SUB: alucontrol = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3)
          // Only R-type (op[5]=1) uses funct7b5 to pick sub; addi never subtracts.
          3'b000:  alucontrol = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b010:  alucontrol = ALU_SLT;
          3'b110:  alucontrol = ALU_OR;
          3'b111:  alucontrol = ALU_AND;
          default: alucontrol = ALU_ADD;
        endcase
      end
      default: alucontrol = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RV32I control FSM: sequences FETCH, DECODE and 1-3 execute states.
// Ports: clk, reset (sync, active-high), op/funct3/funct7b5 from the IR, zero flag in;
//        datapath selects, alucontrol, write enables and illegal-opcode pulse out.
module multicycle_controller
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       zero,
  output logic [1:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic [2:0] alucontrol,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  state_t     state, state_next;
  logic [1:0] aluop;
  logic       pcupdate;
  logic       branch;

  always_ff @(posedge clk) begin
    if (reset) state <= FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    resultsrc  = 2'b00;
    adrsrc     = 1'b0;
    aluop      = ALUOP_ADD;
    irwrite    = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    regwrite   = 1'b0;
    memwrite   = 1'b0;
    illegal    = 1'b0;

    case (state)
      FETCH: begin
        irwrite    = 1'b1;
        alusrcb    = 2'b10;
        resultsrc  = 2'b10;
        pcupdate   = 1'b1;
        state_next = DECODE;
      end
      DECODE: begin
        // OldPC + ImmExt: branch target is ready in ALUOut for BEQ.
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LW, OP_SW: state_next = MEMADR;
          OP_R:         state_next = EXECUTER;
          OP_I:         state_next = EXECUTEI;
          OP_BEQ:       state_next = BEQ;
          OP_JAL:       state_next = JAL;
          default: begin
            state_next = FETCH;
            illegal    = 1'b1;
          end
        endcase
      end
      MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = (op == OP_LW) ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        adrsrc     = 1'b1;
        state_next = MEMWB;
      end
      MEMWB: begin
        resultsrc  = 2'b01;
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      MEMWRITE: begin
        adrsrc     = 1'b1;
        memwrite   = 1'b1;
        state_next = FETCH;
      end
      EXECUTER: begin
        alusrca    = 2'b10;
        aluop      = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      EXECUTEI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        aluop      = ALUOP_FUNCT;
        state_next = ALUWB;
      end
      ALUWB: begin
        regwrite   = 1'b1;
        state_next = FETCH;
      end
      BEQ: begin
        alusrca    = 2'b10;
        aluop      = ALUOP_SUB;
        branch     = 1'b1;
        state_next = FETCH;
      end
      JAL: begin
        // OldPC + 4 is the link value; ALUOut (target from DECODE) goes to PC.
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcupdate   = 1'b1;
        state_next = ALUWB;
      end
      default: state_next = FETCH;
    endcase

    // During reset present FETCH selects but suppress every write.
    if (reset) begin
      alusrca   = 2'b00;
      alusrcb   = 2'b10;
      resultsrc = 2'b10;
      adrsrc    = 1'b0;
      aluop     = ALUOP_ADD;
      irwrite   = 1'b0;
      pcupdate  = 1'b0;
      branch    = 1'b0;
      regwrite  = 1'b0;
      memwrite  = 1'b0;
      illegal   = 1'b0;
    end
  end

  assign pcwrite = pcupdate | (branch & zero);
  assign immsrc  = imm_for_op(op);

  alu_decoder u_alu_decoder (
    .aluop      (aluop),
    .funct3     (funct3),
    .op5        (op[5]),
    .funct7b5   (funct7b5),
    .alucontrol (alucontrol)
  );

endmodule

// File: tb/tb_multicycle_controller.sv
// Testbench for multicycle_controller: directed test-plan steps then randomized
// instruction streams with occasional mid-instruction resets, checked per cycle.
// Expected outputs come from a per-phase model of the control table.
module tb_multicycle_controller;

  logic       clk;
  logic       reset;
  logic [6:0] op;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       zero;
  logic [1:0] immsrc, alusrca, alusrcb, resultsrc;
  logic       adrsrc;
  logic [2:0] alucontrol;
  logic       irwrite, pcwrite, regwrite, memwrite, illegal;

  int tests_run = 0;
  int tests_failed = 0;

  multicycle_controller dut (
    .clk        (clk),
    .reset      (reset),
    .op         (op),
    .funct3     (funct3),
    .funct7b5   (funct7b5),
    .zero       (zero),
    .immsrc     (immsrc),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .resultsrc  (resultsrc),
    .adrsrc     (adrsrc),
    .alucontrol (alucontrol),
    .irwrite    (irwrite),
    .pcwrite    (pcwrite),
    .regwrite   (regwrite),
    .memwrite   (memwrite),
    .illegal    (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
  localparam logic [6:0] IT = 7'b0010011, BQ = 7'b1100011, JL = 7'b1101111;

  // Cycles per instruction including FETCH.
  function automatic int cpi(input logic [6:0] o);
    case (o)
      LW:                 return 5;
      SW, RT, IT, JL:     return 4;
      BQ:                 return 3;
      default:            return 2;
    endcase
  endfunction

  // Name of the k-th step of an instruction with opcode o.
  function automatic string phase_of(input logic [6:0] o, input int k);
    if (k == 0) return "FETCH";
    if (k == 1) return "DECODE";
    case (o)
      LW: return (k == 2) ? "MEMADR" : (k == 3) ? "MEMREAD" : "MEMWB";
      SW: return (k == 2) ? "MEMADR" : "MEMWRITE";
      RT: return (k == 2) ? "EXECUTER" : "ALUWB";
      IT: return (k == 2) ? "EXECUTEI" : "ALUWB";
      BQ: return "BEQ";
      JL: return (k == 2) ? "JAL" : "ALUWB";
      default: return "FETCH";
    endcase
  endfunction

  // Expected {immsrc,alusrca,alusrcb,resultsrc,adrsrc,alucontrol,irwrite,pcwrite,regwrite,memwrite,illegal}.
  function automatic logic [16:0] expect_vec(input logic [6:0] o, input logic [2:0] f3,
                                              input logic f7, input logic z,
                                              input string ph, input logic rst);
    logic [1:0] im, a, b, rs, aop;
    logic [2:0] ac;
    logic       ad, ir, pcu, br, rw, mw, il, supported;
    string      p;
    p  = rst ? "FETCH" : ph;
    im = (o == SW) ? 2'd1 : (o == BQ) ? 2'd2 : (o == JL) ? 2'd3 : 2'd0;
    a = 0; b = 0; rs = 0; aop = 0; ad = 0; ir = 0; pcu = 0; br = 0; rw = 0; mw = 0; il = 0;
    supported = (o == LW) || (o == SW) || (o == RT) || (o == IT) || (o == BQ) || (o == JL);
    if (p == "FETCH")         begin ir = 1; b = 2; rs = 2; pcu = 1; end
    else if (p == "DECODE")   begin a = 1; b = 1; il = !supported; end
    else if (p == "MEMADR")   begin a = 2; b = 1; end
    else if (p == "MEMREAD")  begin ad = 1; end
    else if (p == "MEMWB")    begin rs = 1; rw = 1; end
    else if (p == "MEMWRITE") begin ad = 1; mw = 1; end
    else if (p == "EXECUTER") begin a = 2; aop = 2; end
    else if (p == "EXECUTEI") begin a = 2; b = 1; aop = 2; end
    else if (p == "ALUWB")    begin rw = 1; end
    else if (p == "BEQ")      begin a = 2; aop = 1; br = 1; end
    else if (p == "JAL")      begin a = 1; b = 2; pcu = 1; end
    if (rst) begin ir = 0; pcu = 0; rw = 0; mw = 0; il = 0; end
    if (aop == 0)      ac = 3'd0;
    else if (aop == 1) ac = 3'd1;
    else ac = (f3 == 3'd0) ? ((o[5] && f7) ? 3'd1 : 3'd0) :
              (f3 == 3'd2) ? 3'd5 : (f3 == 3'd6) ? 3'd3 : (f3 == 3'd7) ? 3'd2 : 3'd0;
    return {im, a, b, rs, ad, ac, ir, pcu | (br & z), rw, mw, il};
  endfunction

  function automatic logic [16:0] observed();
    return {immsrc, alusrca, alusrcb, resultsrc, adrsrc, alucontrol,
            irwrite, pcwrite, regwrite, memwrite, illegal};
  endfunction

  // Called at posedge+1: drive zero, compare at the falling edge, advance to next posedge+1.
  task automatic cycle_check(input string tag, input string ph, input logic rst, input int zmode);
    logic [16:0] exp_v, obs_v;
    zero = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
    @(negedge clk);
    exp_v = expect_vec(op, funct3, funct7b5, zero, ph, rst);
    obs_v = observed();
    tests_run++;
    assert (obs_v === exp_v)
    else begin
      tests_failed++;
      $error("FAIL %s/%s op=%b: observed %b expected %b", tag, ph, op, obs_v, exp_v);
    end
    @(posedge clk);
    #1;
  endtask

  // Runs one instruction; if abort_at < cpi, reset is raised at that step for rst_len cycles.
  task automatic run_instr(input string tag, input logic [6:0] o, input logic [2:0] f3,
                           input logic f7, input int zmode, input int abort_at, input int rst_len);
    op = o; funct3 = f3; funct7b5 = f7;
    for (int k = 0; k < cpi(o); k++) begin
      if (k == abort_at) begin
        reset = 1'b1;
        for (int r = 0; r < rst_len; r++) cycle_check({tag, "_rst"}, "FETCH", 1'b1, -1);
        reset = 1'b0;
        return;
      end
      cycle_check(tag, phase_of(o, k), 1'b0, zmode);
    end
  endtask

  logic [6:0] bad_ops [6];
  logic [6:0] good_ops [6];

  initial begin
    bad_ops  = '{7'h00, 7'h37, 7'h17, 7'h67, 7'h73, 7'h7f};
    good_ops = '{LW, SW, RT, IT, BQ, JL};
    reset = 1'b1; op = 7'h00; funct3 = 3'd0; funct7b5 = 1'b0; zero = 1'b0;
    @(posedge clk);
    #1;
    // Power-on reset: FETCH selects, no writes.
    for (int r = 0; r < 2; r++) cycle_check("por", "FETCH", 1'b1, -1);
    reset = 1'b0;

    // Directed steps.
    run_instr("lw",      LW, 3'd2, 1'b0, -1, 99, 0);
    run_instr("sw",      SW, 3'd2, 1'b0, -1, 99, 0);
    run_instr("r_sub",   RT, 3'd0, 1'b1, -1, 99, 0);
    run_instr("i_add",   IT, 3'd0, 1'b1, -1, 99, 0);
    run_instr("beq_tk",  BQ, 3'd0, 1'b0,  1, 99, 0);
    run_instr("beq_nt",  BQ, 3'd0, 1'b0,  0, 99, 0);
    run_instr("jal",     JL, 3'd0, 1'b0, -1, 99, 0);
    run_instr("illegal", 7'h00, 3'd0, 1'b0, -1, 99, 0);
    // Reset held three cycles in MEMWB, then a full instruction from FETCH.
    run_instr("lw_abort", LW, 3'd2, 1'b0, -1, 4, 3);
    run_instr("after_rst", RT, 3'd7, 1'b0, -1, 99, 0);
    run_instr("r_slt",   RT, 3'd2, 1'b0, -1, 99, 0);
    run_instr("i_or",    IT, 3'd6, 1'b1, -1, 99, 0);

    // Randomized instruction stream with occasional mid-instruction resets.
    for (int n = 0; n < 120; n++) begin
      logic [6:0] o;
      int ab, rl;
      o  = ($urandom_range(0, 7) == 0) ? bad_ops[$urandom_range(0, 5)] : good_ops[$urandom_range(0, 5)];
      ab = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 4)) : 99;
      rl = int'($urandom_range(1, 3));
      run_instr("rand", o, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), -1, ab, rl);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
